// File: rtl/arp_pkg.sv
// arp_pkg: shared ARP constants, field offsets and parser state enum
package arp_pkg;
  localparam logic [15:0] ARP_OPER_REQUEST = 16'h0001;
  localparam logic [15:0] ARP_OPER_REPLY   = 16'h0002;
  localparam logic [15:0] ARP_HTYPE_ETH    = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4   = 16'h0800;
  localparam logic [7:0]  ARP_HLEN_ETH     = 8'd6;
  localparam logic [7:0]  ARP_PLEN_IPV4    = 8'd4;
  localparam int unsigned ARP_PAYLOAD_LEN  = 28;
  localparam int unsigned ARP_OFF_HTYPE    = 0;
  localparam int unsigned ARP_OFF_PTYPE    = 2;
  localparam int unsigned ARP_OFF_HLEN     = 4;
  localparam int unsigned ARP_OFF_PLEN     = 5;
  localparam int unsigned ARP_OFF_OPER     = 6;
  localparam int unsigned ARP_OFF_SHA      = 8;
  localparam int unsigned ARP_OFF_SPA      = 14;
  localparam int unsigned ARP_OFF_THA      = 18;
  localparam int unsigned ARP_OFF_TPA      = 24;
  typedef enum logic [1:0] {ARP_IDLE, ARP_CAPTURE, ARP_PAD, ARP_REPORT} arp_rx_state_e;
endpackage

// File: rtl/arp_rx_parser.sv
// arp_rx_parser: ARP receive parser with end-of-frame report; ARP_RX_STRICT_CHECK_EN adds header checks
module arp_rx_parser
  import arp_pkg::*;
#(
  parameter logic [31:0] P_LOCAL_IP = 32'hC0A8_0064
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_local_ip,
  input  logic        i_local_ip_valid,
  input  logic [7:0]  i_arp_data,
  input  logic        i_arp_valid,
  input  logic        i_arp_last,
  output logic [47:0] o_sender_mac,
  output logic [31:0] o_sender_ip,
  output logic        o_is_request,
  output logic        o_is_reply,
  output logic        o_recv_valid
);
  localparam logic [4:0] LAST_IDX = 5'(ARP_PAYLOAD_LEN - 1);
  arp_rx_state_e state;
  logic [4:0]  count;
  logic [7:0]  sh [ARP_PAYLOAD_LEN];
  logic [31:0] local_ip;
  logic [15:0] htype, ptype, oper;
  logic [7:0]  hlen, plen;
  logic [47:0] sha;
  logic [31:0] spa, tpa;
  logic        at_end, hdr_ok, accept;
  // Field view of the shadow bytes; the final TPA byte is taken live so the report can be registered on the last byte's edge
  always_comb begin
    htype  = {sh[ARP_OFF_HTYPE], sh[ARP_OFF_HTYPE+1]};
    ptype  = {sh[ARP_OFF_PTYPE], sh[ARP_OFF_PTYPE+1]};
    hlen   = sh[ARP_OFF_HLEN];
    plen   = sh[ARP_OFF_PLEN];
    oper   = {sh[ARP_OFF_OPER], sh[ARP_OFF_OPER+1]};
    sha    = {sh[ARP_OFF_SHA], sh[ARP_OFF_SHA+1], sh[ARP_OFF_SHA+2],
              sh[ARP_OFF_SHA+3], sh[ARP_OFF_SHA+4], sh[ARP_OFF_SHA+5]};
    spa    = {sh[ARP_OFF_SPA], sh[ARP_OFF_SPA+1], sh[ARP_OFF_SPA+2], sh[ARP_OFF_SPA+3]};
    tpa    = {sh[ARP_OFF_TPA], sh[ARP_OFF_TPA+1], sh[ARP_OFF_TPA+2],
              state == ARP_CAPTURE ? i_arp_data : sh[ARP_OFF_TPA+3]};
    at_end = i_arp_valid && i_arp_last &&
             (state == ARP_PAD || (state == ARP_CAPTURE && count == LAST_IDX));
`ifdef ARP_RX_STRICT_CHECK_EN
    hdr_ok = htype == ARP_HTYPE_ETH && ptype == ARP_PTYPE_IPV4 &&
             hlen == ARP_HLEN_ETH && plen == ARP_PLEN_IPV4;
`else
    hdr_ok = 1'b1;
`endif
    accept = at_end && hdr_ok && tpa == local_ip &&
             (oper == ARP_OPER_REQUEST || oper == ARP_OPER_REPLY);
  end
  // Shadow capture: a byte seen outside CAPTURE is always byte 0 of a new frame
  always_ff @(posedge i_clk) begin
    if (i_arp_valid && state != ARP_PAD) sh[state == ARP_CAPTURE ? count : 5'd0] <= i_arp_data;
  end
  // Frame FSM, local address register and registered report outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ARP_IDLE;
      count        <= '0;
      local_ip     <= P_LOCAL_IP;
      o_sender_mac <= '0;
      o_sender_ip  <= '0;
      o_is_request <= 1'b0;
      o_is_reply   <= 1'b0;
      o_recv_valid <= 1'b0;
    end else begin
      if (i_local_ip_valid) local_ip <= i_local_ip;
      o_recv_valid <= accept;
      if (accept) begin
        o_sender_mac <= sha;
        o_sender_ip  <= spa;
        o_is_request <= oper == ARP_OPER_REQUEST;
        o_is_reply   <= oper == ARP_OPER_REPLY;
      end
      case (state)
        ARP_IDLE, ARP_REPORT: begin
          state <= i_arp_valid && !i_arp_last ? ARP_CAPTURE : ARP_IDLE;
          count <= i_arp_valid && !i_arp_last ? 5'd1 : 5'd0;
        end
        ARP_CAPTURE: if (i_arp_valid) begin
          state <= i_arp_last ? (count == LAST_IDX ? ARP_REPORT : ARP_IDLE)
                              : (count == LAST_IDX ? ARP_PAD : ARP_CAPTURE);
          count <= i_arp_last && count != LAST_IDX ? 5'd0 : count + 5'd1;
        end
        default: if (i_arp_valid && i_arp_last) state <= ARP_REPORT;
      endcase
    end
  end
endmodule

// File: tb/tb_arp_rx_parser.sv
// tb_arp_rx_parser: directed plus randomized frames checked against a byte-queue model
module tb_arp_rx_parser;
  localparam logic [31:0] DEF_IP = 32'hC0A8_0064;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] local_ip = '0;
  logic        local_ip_valid = 1'b0;
  logic [7:0]  data = '0;
  logic        valid = 1'b0;
  logic        last = 1'b0;
  logic [47:0] sender_mac;
  logic [31:0] sender_ip;
  logic        is_request, is_reply, recv_valid;
  int checks = 0;
  int failures = 0;
  logic [7:0]  fq[$];
  logic [31:0] m_local = DEF_IP;
  logic        e_valid = 1'b0, e_req = 1'b0, e_rep = 1'b0;
  logic [47:0] e_mac = '0;
  logic [31:0] e_ip = '0;

  arp_rx_parser dut (
    .i_clk(clk), .i_rst(rst), .i_local_ip(local_ip), .i_local_ip_valid(local_ip_valid),
    .i_arp_data(data), .i_arp_valid(valid), .i_arp_last(last),
    .o_sender_mac(sender_mac), .o_sender_ip(sender_ip), .o_is_request(is_request),
    .o_is_reply(is_reply), .o_recv_valid(recv_valid)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void judge();
    logic [15:0] oper;
    logic [31:0] tpa;
    logic ok;
    if (fq.size() < 28) return;
    oper = {fq[6], fq[7]};
    tpa  = {fq[24], fq[25], fq[26], fq[27]};
    ok   = tpa == m_local && (oper == 16'd1 || oper == 16'd2);
`ifdef ARP_RX_STRICT_CHECK_EN
    ok = ok && {fq[0], fq[1]} == 16'h0001 && {fq[2], fq[3]} == 16'h0800 && fq[4] == 8'd6 && fq[5] == 8'd4;
`endif
    if (ok) begin
      e_valid = 1'b1;
      e_mac   = {fq[8], fq[9], fq[10], fq[11], fq[12], fq[13]};
      e_ip    = {fq[14], fq[15], fq[16], fq[17]};
      e_req   = oper == 16'd1;
      e_rep   = oper == 16'd2;
    end
  endfunction

  task automatic step(logic r, logic v, logic [7:0] d, logic l, logic lv, logic [31:0] lip);
    @(negedge clk);
    check("recv_valid", 64'(recv_valid), 64'(e_valid));
    check("sender_mac", 64'(sender_mac), 64'(e_mac));
    check("sender_ip", 64'(sender_ip), 64'(e_ip));
    check("is_request", 64'(is_request), 64'(e_req));
    check("is_reply", 64'(is_reply), 64'(e_rep));
    e_valid = 1'b0;
    if (r) begin
      fq.delete();
      m_local = DEF_IP;
      e_mac = '0; e_ip = '0; e_req = 1'b0; e_rep = 1'b0;
    end else begin
      if (v) begin
        fq.push_back(d);
        if (l) begin
          judge();
          fq.delete();
        end
      end
      if (lv) m_local = lip;
    end
    rst = r; valid = v; data = d; last = l; local_ip_valid = lv; local_ip = lip;
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 1'b0, 8'(($urandom)), 1'b0, 1'b0, '0);
  endtask

  task automatic load_ip(logic [31:0] ip);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, ip);
  endtask

  task automatic send_frame(logic [15:0] oper, logic [47:0] sha, logic [31:0] spa, logic [31:0] tpa,
                            int len, int gmin, int gmax, logic [15:0] ptype, logic with_last);
    logic [7:0] b[$];
    b = '{8'h00, 8'h01, ptype[15:8], ptype[7:0], 8'd6, 8'd4, oper[15:8], oper[7:0]};
    for (int k = 5; k >= 0; k--) b.push_back(sha[8*k +: 8]);
    for (int k = 3; k >= 0; k--) b.push_back(spa[8*k +: 8]);
    for (int k = 0; k < 6; k++) b.push_back(8'($urandom));
    for (int k = 3; k >= 0; k--) b.push_back(tpa[8*k +: 8]);
    while (b.size() < len) b.push_back(8'($urandom));
    while (b.size() > len) void'(b.pop_back());
    for (int i = 0; i < len; i++) begin
      idle(int'($urandom_range(gmax, gmin)));
      step(1'b0, 1'b1, b[i], with_last && i == len - 1, 1'b0, '0);
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, '0);
  endtask

  initial begin
    do_reset();
    idle(2);
    send_frame(16'd1, 48'h001122334455, 32'hC0A80002, 32'hC0A80064, 46, 0, 0, 16'h0800, 1'b1);
    idle(2);
    send_frame(16'd1, 48'h001122334455, 32'hC0A80003, 32'hC0A80065, 46, 0, 0, 16'h0800, 1'b1);
    idle(2);
    send_frame(16'd1, 48'hAABBCCDDEEFF, 32'hC0A80009, 32'hC0A80064, 21, 0, 0, 16'h0800, 1'b1);
    send_frame(16'd1, 48'h665544332211, 32'hC0A80007, 32'hC0A80064, 28, 0, 0, 16'h0800, 1'b1);
    idle(2);
    send_frame(16'd2, 48'h0A0B0C0D0E0F, 32'hC0A80011, 32'hC0A80064, 46, 3, 3, 16'h0800, 1'b1);
    send_frame(16'd1, 48'h102030405060, 32'hC0A80012, 32'hC0A80064, 46, 0, 0, 16'h0800, 1'b1);
    idle(3);
    load_ip(32'h0A000001);
    send_frame(16'd1, 48'h111111111111, 32'h0A000002, 32'h0A000001, 46, 0, 0, 16'h0800, 1'b1);
    send_frame(16'd1, 48'h222222222222, 32'h0A000003, 32'hC0A80064, 46, 0, 0, 16'h0800, 1'b1);
    send_frame(16'd3, 48'h333333333333, 32'h0A000004, 32'h0A000001, 30, 0, 0, 16'h0800, 1'b1);
    send_frame(16'd1, 48'h444444444444, 32'h0A000005, 32'h0A000001, 46, 0, 0, 16'h86DD, 1'b1);
    idle(2);
    send_frame(16'd1, 48'h555555555555, 32'h0A000006, 32'h0A000001, 15, 0, 0, 16'h0800, 1'b0);
    do_reset();
    send_frame(16'd2, 48'h666666666666, 32'hC0A80066, 32'hC0A80064, 40, 0, 1, 16'h0800, 1'b1);
    idle(2);
    for (int n = 0; n < 150; n++) begin
      logic [15:0] op;
      logic [31:0] tp;
      int len, sel;
      sel = int'($urandom_range(3));
      op  = sel == 0 ? 16'd1 : sel == 1 ? 16'd2 : sel == 2 ? 16'd3 : 16'($urandom);
      tp  = $urandom_range(3) != 0 ? m_local : $urandom;
      sel = int'($urandom_range(3));
      len = sel == 0 ? int'($urandom_range(27, 1)) : sel == 1 ? 28 : int'($urandom_range(60, 29));
      if ($urandom_range(19) == 0) begin
        send_frame(op, {$urandom, 16'($urandom)}, $urandom, tp, len, 0, 1, 16'h0800, 1'b0);
        do_reset();
      end else begin
        send_frame(op, {$urandom, 16'($urandom)}, $urandom, tp, len, 0, int'($urandom_range(2)),
                   $urandom_range(7) == 0 ? 16'h86DD : 16'h0800, 1'b1);
      end
      if ($urandom_range(9) == 0) load_ip($urandom_range(1) == 0 ? DEF_IP : 32'h0A000001);
      if ($urandom_range(1) == 0) idle(int'($urandom_range(2)));
    end
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
